// File: rtl/sequential_subtractor_if.sv
// sequential_subtractor_if: start/operand request and result/flag bundle for the bit-serial subtractor
interface sequential_subtractor_if #(parameter int WIDTH = 16);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;
    logic             zero;
    logic             done;
    logic             busy;
    modport master (output start, a, b, input diff, borrow, overflow, zero, done, busy);
    modport slave (input start, a, b, output diff, borrow, overflow, zero, done, busy);
endinterface

// File: rtl/sequential_subtractor.sv
// sequential_subtractor: bit-serial a - b, LSB first, with borrow/overflow/zero flags
module sequential_subtractor #(parameter int WIDTH = 16) (
    input logic                clk,
    input logic                reset,
    sequential_subtractor_if.slave s
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int IW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;
    state_t state, state_d;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] a_r, b_r, res;
    logic br, a_i, b_i, d_i, br_d, last;
    assign a_i = a_r[cnt[IW-1:0]];
    assign b_i = b_r[cnt[IW-1:0]];
    assign d_i = a_i ^ b_i ^ br;
    assign br_d = (~a_i & b_i) | (~(a_i ^ b_i) & br);
    assign last = cnt == CW'(WIDTH - 1);
    assign s.busy = state != IDLE;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_d;
    end
    always_comb begin
        state_d = state;
        state_d = state == IDLE ? (s.start ? SUB : IDLE) :
                  state == SUB  ? (last ? DONE : SUB) : IDLE;
    end
    // results are registered on the DONE->IDLE edge, so done never overlaps busy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r        <= '0;
            b_r        <= '0;
            res        <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            s.diff     <= '0;
            s.borrow   <= 1'b0;
            s.overflow <= 1'b0;
            s.zero     <= 1'b0;
            s.done     <= 1'b0;
        end else begin
            s.done <= 1'b0;
            if (state == IDLE && s.start) begin
                a_r <= s.a;
                b_r <= s.b;
                res <= '0;
                br  <= 1'b0;
                cnt <= '0;
            end else if (state == SUB) begin
                res[cnt[IW-1:0]] <= d_i;
                br  <= br_d;
                cnt <= cnt + 1'b1;
            end else if (state == DONE) begin
                s.diff     <= res;
                s.borrow   <= br;
                s.overflow <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (res[WIDTH-1] != a_r[WIDTH-1]);
                s.zero     <= res == '0;
                s.done     <= 1'b1;
            end
        end
    end
endmodule
